// File: rtl/mcu_word_framer.sv
// mcu_word_framer: aligns on HEADER, emits header plus FRAME_WORDS byte-swapped words; define MCU_FRAMER_TIMEOUT_EN for the idle timeout
module mcu_word_framer #(
  parameter logic [15:0] HEADER = 16'hC7E5,
  parameter int FRAME_WORDS = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic [1:0]  state,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt
);
  typedef enum logic [1:0] {HUNT = 2'd0, WAIT_LO = 2'd1, WAIT_HI = 2'd2, BAD = 2'd3} state_t;
  state_t     st;
  logic [7:0] prev_byte, lo_byte, words_left;
  logic       prev_ok, timeout;
  assign state = st;
`ifdef MCU_FRAMER_TIMEOUT_EN
  logic [15:0] idle_cnt;
  assign timeout = !byte_valid && idle_cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_in) begin
    if (rst) begin
      idle_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      idle_cnt <= (byte_valid || timeout || st == BAD) ? '0 : idle_cnt + 16'd1;
      if (timeout && (st == WAIT_LO || st == WAIT_HI) && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
  assign drop_cnt = '0;
`endif
  always_ff @(posedge clk_in) begin
    if (rst) begin
      st         <= HUNT;
      prev_byte  <= '0;
      prev_ok    <= 1'b0;
      lo_byte    <= '0;
      words_left <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      word_valid <= 1'b0;
      word_out   <= '0;
      if (timeout) begin
        prev_ok <= 1'b0;
        st      <= HUNT;
      end else if (byte_valid) begin
        case (st)
          HUNT:
            if (prev_ok && {prev_byte, byte_in} == HEADER) begin
              word_valid <= 1'b1;
              word_out   <= {byte_in, prev_byte};
              words_left <= 8'(FRAME_WORDS);
              prev_ok    <= 1'b0;
              st         <= WAIT_LO;
            end else begin
              prev_byte <= byte_in;
              prev_ok   <= 1'b1;
            end
          WAIT_LO: begin
            lo_byte <= byte_in;
            st      <= WAIT_HI;
          end
          WAIT_HI: begin
            word_valid <= 1'b1;
            word_out   <= {byte_in, lo_byte};
            words_left <= words_left - 8'd1;
            if (words_left == 8'd1) frame_cnt <= frame_cnt + 16'd1;
            st <= (words_left == 8'd1) ? HUNT : WAIT_LO;
          end
          default: st <= HUNT;
        endcase
      end else if (st == BAD) begin
        st <= HUNT;
      end
    end
  end
endmodule

// File: tb/tb_mcu_word_framer.sv
// tb_mcu_word_framer: table-driven and scoreboarded checks of mcu_word_framer (FRAME_WORDS 1 and 3, TIMEOUT_CYCLES 10)
module tb_mcu_word_framer;
  typedef struct packed {logic [7:0] b; logic v; logic s; logic [15:0] w;} vec_t;
  typedef struct packed {logic [15:0] w; logic [31:0] c;} exp_t;
  logic clk_in = 0, rst = 1;
  logic [7:0] b1 = 0, b3 = 0;
  logic v1 = 0, v3 = 0;
  logic [15:0] w1, w3, fc1, fc3;
  logic wv1, wv3;
  logic [1:0] s1, s3;
  logic [7:0] dc1, dc3;
  logic [31:0] cyc = 0;
  int checks = 0, failures = 0;
  exp_t q1[$], q3[$];
  vec_t t1[20], t3[8], tr[5];
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  mcu_word_framer #(.FRAME_WORDS(1), .TIMEOUT_CYCLES(10)) d1 (
    .clk_in(clk_in), .rst(rst), .byte_in(b1), .byte_valid(v1), .word_out(w1),
    .word_valid(wv1), .state(s1), .frame_cnt(fc1), .drop_cnt(dc1));
  mcu_word_framer #(.FRAME_WORDS(3), .TIMEOUT_CYCLES(10)) d3 (
    .clk_in(clk_in), .rst(rst), .byte_in(b3), .byte_valid(v3), .word_out(w3),
    .word_valid(wv3), .state(s3), .frame_cnt(fc3), .drop_cnt(dc3));
  function automatic vec_t by(input logic [7:0] b);
    return '{b, 1'b1, 1'b0, 16'h0};
  endfunction
  function automatic vec_t ws(input logic [7:0] b, input logic [15:0] w);
    return '{b, 1'b1, 1'b1, w};
  endfunction
  function automatic vec_t id();
    return '{8'h00, 1'b0, 1'b0, 16'h0};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic drive(input bit sel3, input vec_t t);
    @(negedge clk_in);
    if (sel3) begin
      b3 = t.b; v3 = t.v;
      if (t.s) q3.push_back('{t.w, cyc + 1});
    end else begin
      b1 = t.b; v1 = t.v;
      if (t.s) q1.push_back('{t.w, cyc + 1});
    end
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b0, id());
    #1;
  endtask
  always @(negedge clk_in) begin
    exp_t e;
    checks++;
    if (wv1) begin
      if (q1.size() == 0) begin
        failures++; $display("FAIL d1_unexpected_word got=%h", w1);
      end else begin
        e = q1.pop_front();
        if (w1 !== e.w || cyc !== e.c) begin
          failures++; $display("FAIL d1_word got=%h@%0d exp=%h@%0d", w1, cyc, e.w, e.c);
        end
      end
    end else if (w1 !== 16'h0) begin
      failures++; $display("FAIL d1_idle_zero got=%h exp=0", w1);
    end
  end
  always @(negedge clk_in) begin
    exp_t e;
    checks++;
    if (wv3) begin
      if (q3.size() == 0) begin
        failures++; $display("FAIL d3_unexpected_word got=%h", w3);
      end else begin
        e = q3.pop_front();
        if (w3 !== e.w || cyc !== e.c) begin
          failures++; $display("FAIL d3_word got=%h@%0d exp=%h@%0d", w3, cyc, e.w, e.c);
        end
      end
    end else if (w3 !== 16'h0) begin
      failures++; $display("FAIL d3_idle_zero got=%h exp=0", w3);
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    t1 = '{by(8'hC7), ws(8'hE5, 16'hE5C7), by(8'h12), ws(8'h03, 16'h0312),
           by(8'h00), by(8'hC7), by(8'hC7), ws(8'hE5, 16'hE5C7), by(8'h05), ws(8'h01, 16'h0105),
           by(8'hC7), id(), ws(8'hE5, 16'hE5C7), id(), id(), by(8'h34), ws(8'h12, 16'h1234),
           by(8'hC7), by(8'h00), by(8'hE5)};
    t3 = '{by(8'hC7), ws(8'hE5, 16'hE5C7), by(8'hC7), ws(8'hE5, 16'hE5C7),
           by(8'hAA), ws(8'hBB, 16'hBBAA), by(8'h01), ws(8'h02, 16'h0201)};
    tr = '{by(8'h03), by(8'hC7), ws(8'hE5, 16'hE5C7), by(8'h04), ws(8'h00, 16'h0004)};
    repeat (2) @(negedge clk_in);
    #1;
    chk("rst_word_out", w1, 0); chk("rst_word_valid", wv1, 0); chk("rst_state", s1, 0);
    chk("rst_frame_cnt", fc1, 0); chk("rst_drop_cnt", dc1, 0); chk("rst_state_d3", s3, 0);
    rst = 0;
    foreach (t1[i]) drive(1'b0, t1[i]);
    idle(3);
    chk("table_frame_cnt", fc1, 3); chk("table_state", s1, 0); chk("table_q_empty", q1.size(), 0);
    foreach (t3[i]) drive(1'b1, t3[i]);
    repeat (3) drive(1'b1, id());
    #1;
    chk("fw3_frame_cnt", fc3, 1); chk("fw3_state", s3, 0); chk("fw3_q_empty", q3.size(), 0);
    drive(1'b0, by(8'hC7)); drive(1'b0, ws(8'hE5, 16'hE5C7)); drive(1'b0, by(8'h12));
    idle(10);
    chk("idle9_state", s1, 2);
`ifdef MCU_FRAMER_TIMEOUT_EN
    idle(1);
    chk("timeout_state", s1, 0); chk("timeout_drop", dc1, 1);
    drive(1'b0, by(8'hC7)); drive(1'b0, ws(8'hE5, 16'hE5C7));
    drive(1'b0, by(8'h12)); drive(1'b0, ws(8'h03, 16'h0312));
    idle(3);
    chk("after_timeout_frame", fc1, 4); chk("after_timeout_drop", dc1, 1);
    drive(1'b0, by(8'hC7)); idle(10); drive(1'b0, by(8'hE5));
    idle(3);
    chk("hunt_timeout_no_hdr", s1, 0);
    drive(1'b0, by(8'hC7)); idle(9); drive(1'b0, ws(8'hE5, 16'hE5C7));
    drive(1'b0, by(8'h12)); drive(1'b0, ws(8'h34, 16'h3412));
    idle(3);
    chk("hunt_idle9_frame", fc1, 5);
    for (int i = 0; i < 260; i++) begin
      drive(1'b0, by(8'hC7)); drive(1'b0, ws(8'hE5, 16'hE5C7)); drive(1'b0, by(8'h11));
      idle(11);
    end
    chk("drop_saturate", dc1, 255); chk("drop_sat_state", s1, 0);
`else
    idle(90);
    chk("no_timeout_state", s1, 2);
    drive(1'b0, ws(8'h03, 16'h0312));
    idle(3);
    chk("no_timeout_frame", fc1, 4); chk("no_timeout_drop", dc1, 0);
    drive(1'b0, by(8'hC7)); idle(10); drive(1'b0, ws(8'hE5, 16'hE5C7));
    drive(1'b0, by(8'h12)); drive(1'b0, ws(8'h34, 16'h3412));
    idle(3);
    chk("hunt_no_timeout_frame", fc1, 5);
`endif
    chk("pre_reset_q_empty", q1.size(), 0);
    drive(1'b0, by(8'hC7)); drive(1'b0, ws(8'hE5, 16'hE5C7)); drive(1'b0, by(8'h12));
    @(negedge clk_in);
    rst = 1; v1 = 0;
    @(negedge clk_in);
    rst = 0;
    #1;
    chk("midrst_state", s1, 0); chk("midrst_frame_cnt", fc1, 0); chk("midrst_drop", dc1, 0);
    foreach (tr[i]) drive(1'b0, tr[i]);
    idle(3);
    chk("midrst_after_frame", fc1, 1); chk("midrst_q_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
